// File: rtl/ifu_ift2icb_mp.sv
// Fetch-to-ICB bridge: decodes a fetch PC against NPORT regions, issues one or
// two DW-bit ICB reads and returns a 32-bit instruction with an error flag.
module ifu_ift2icb_mp #(
   parameter int NPORT = 2,
   parameter int DW    = 64,
   parameter int AW    = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ifu_req_valid,
   output logic                  ifu_req_ready,
   input  logic [AW-1:0]         ifu_req_pc,
   output logic                  ifu_rsp_valid,
   input  logic                  ifu_rsp_ready,
   output logic                  ifu_rsp_err,
   output logic [31:0]           ifu_rsp_instr,
   input  logic [NPORT*AW-1:0]   region_base,
   input  logic [NPORT*AW-1:0]   region_mask,
   output logic [NPORT-1:0]      icb_cmd_valid,
   input  logic [NPORT-1:0]      icb_cmd_ready,
   output logic [AW-1:0]         icb_cmd_addr,
   input  logic [NPORT-1:0]      icb_rsp_valid,
   output logic [NPORT-1:0]      icb_rsp_ready,
   input  logic [NPORT-1:0]      icb_rsp_err,
   input  logic [NPORT*DW-1:0]   icb_rsp_rdata
);

   localparam int L    = DW / 8;
   localparam int OFFW = $clog2(L);
   localparam int PW   = (NPORT > 1) ? $clog2(NPORT) : 1;

   typedef enum logic [2:0] {IDLE, CMD1, RSP1, CMD2, RSP2, OUT} state_t;

   state_t           state, state_nxt;
   logic [AW-1:0]    pc_r;
   logic [PW-1:0]    port1, port2;
   logic             cross_r;
   logic [15:0]      leftover;
   logic             err_r;
   logic [31:0]      instr_r;

   logic [OFFW-1:0]  off;
   logic [AW-1:0]    a1, a2;
   logic             req_hit, a2_hit;
   logic [PW-1:0]    req_port, a2_port;
   logic [PW-1:0]    cur_port;
   logic [NPORT-1:0] port_oh;
   logic [DW-1:0]    sel_rdata;
   logic             sel_err;
   logic             req_hs, cmd_hs, rsp_hs;

   // Scanning from the top index down leaves the lowest-index hit as the winner.
   function automatic logic [PW:0] decode(input logic [AW-1:0] a,
                                          input logic [NPORT*AW-1:0] base,
                                          input logic [NPORT*AW-1:0] mask);
      logic [PW:0] r;
      r = '0;
      for (int i = NPORT - 1; i >= 0; i--) begin
         if ((a & mask[i*AW +: AW]) == (base[i*AW +: AW] & mask[i*AW +: AW]))
            r = {1'b1, PW'(i)};
      end
      return r;
   endfunction

   assign off = pc_r[OFFW-1:0];
   assign a1  = {pc_r[AW-1:OFFW], {OFFW{1'b0}}};
   assign a2  = a1 + AW'(L);

   assign {req_hit, req_port} = decode(ifu_req_pc, region_base, region_mask);
   assign {a2_hit, a2_port}   = decode(a2, region_base, region_mask);

   assign cur_port  = (state == CMD2 || state == RSP2) ? port2 : port1;
   assign port_oh   = NPORT'(1) << cur_port;
   assign sel_rdata = icb_rsp_rdata[cur_port*DW +: DW];
   assign sel_err   = |(icb_rsp_err & port_oh);

   assign req_hs = ifu_req_valid & ifu_req_ready;
   assign cmd_hs = |(icb_cmd_valid & icb_cmd_ready);
   assign rsp_hs = |(icb_rsp_valid & icb_rsp_ready);

   always_comb begin
      ifu_req_ready = (state == IDLE);
      ifu_rsp_valid = (state == OUT);
      ifu_rsp_err   = err_r;
      ifu_rsp_instr = instr_r;
      icb_cmd_valid = (state == CMD1 || state == CMD2) ? port_oh : '0;
      icb_rsp_ready = (state == RSP1 || state == RSP2) ? port_oh : '0;
      icb_cmd_addr  = (state == CMD2) ? a2 : a1;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (req_hs) state_nxt = (ifu_req_pc[0] || !req_hit) ? OUT : CMD1;
         CMD1: if (cmd_hs) state_nxt = RSP1;
         RSP1: if (rsp_hs) state_nxt = (sel_err || !cross_r || !a2_hit) ? OUT : CMD2;
         CMD2: if (cmd_hs) state_nxt = RSP2;
         RSP2: if (rsp_hs) state_nxt = OUT;
         OUT:  if (ifu_rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath registers load only on the handshake that leaves each state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         pc_r     <= '0;
         port1    <= '0;
         port2    <= '0;
         cross_r  <= 1'b0;
         leftover <= '0;
         err_r    <= 1'b0;
         instr_r  <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: if (req_hs) begin
               pc_r    <= ifu_req_pc;
               port1   <= req_port;
               cross_r <= (ifu_req_pc[OFFW-1:0] == OFFW'(L - 2));
               err_r   <= ifu_req_pc[0] | ~req_hit;
               instr_r <= '0;
            end
            RSP1: if (rsp_hs) begin
               if (sel_err) begin
                  err_r   <= 1'b1;
                  instr_r <= '0;
               end else if (!cross_r) begin
                  err_r   <= 1'b0;
                  instr_r <= sel_rdata[{off, 3'b000} +: 32];
               end else begin
                  leftover <= sel_rdata[DW-1 -: 16];
                  port2    <= a2_port;
                  err_r    <= ~a2_hit;
                  instr_r  <= '0;
               end
            end
            RSP2: if (rsp_hs) begin
               instr_r <= {sel_rdata[15:0], leftover};
               err_r   <= sel_err;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ifu_ift2icb_mp.sv
// Self-checking bench for ifu_ift2icb_mp: scoreboard queues hold expected ICB
// commands and fetch responses, popped as the DUT produces them.
module tb_ifu_ift2icb_mp;

   localparam int NPORT = 2;
   localparam int DW    = 64;
   localparam int AW    = 32;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                ifu_req_valid;
   logic                ifu_req_ready;
   logic [AW-1:0]       ifu_req_pc;
   logic                ifu_rsp_valid;
   logic                ifu_rsp_ready;
   logic                ifu_rsp_err;
   logic [31:0]         ifu_rsp_instr;
   logic [NPORT*AW-1:0] region_base;
   logic [NPORT*AW-1:0] region_mask;
   logic [NPORT-1:0]    icb_cmd_valid;
   logic [NPORT-1:0]    icb_cmd_ready;
   logic [AW-1:0]       icb_cmd_addr;
   logic [NPORT-1:0]    icb_rsp_valid;
   logic [NPORT-1:0]    icb_rsp_ready;
   logic [NPORT-1:0]    icb_rsp_err;
   logic [NPORT*DW-1:0] icb_rsp_rdata;

   typedef struct {int port; logic [31:0] addr;} cmd_t;
   typedef struct {logic err; logic [31:0] instr;} rsp_t;

   cmd_t cmd_q[$];
   rsp_t rsp_q[$];
   int   checks = 0;
   int   errors = 0;

   ifu_ift2icb_mp #(.NPORT(NPORT), .DW(DW), .AW(AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_pc(ifu_req_pc),
      .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready),
      .ifu_rsp_err(ifu_rsp_err), .ifu_rsp_instr(ifu_rsp_instr),
      .region_base(region_base), .region_mask(region_mask),
      .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready), .icb_cmd_addr(icb_cmd_addr),
      .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready),
      .icb_rsp_err(icb_rsp_err), .icb_rsp_rdata(icb_rsp_rdata)
   );

   always #5 clk = ~clk;

   task automatic expect_cmd(input int port, input logic [31:0] addr);
      cmd_t c;
      c.port = port; c.addr = addr;
      cmd_q.push_back(c);
   endtask

   task automatic expect_rsp(input logic err, input logic [31:0] instr);
      rsp_t r;
      r.err = err; r.instr = instr;
      rsp_q.push_back(r);
   endtask

   task automatic do_req(input logic [31:0] pc);
      @(negedge clk);
      ifu_req_valid = 1'b1;
      ifu_req_pc    = pc;
      checks++;
      if (ifu_req_ready !== 1'b1) begin errors++; $display("[TB] FAIL req_ready pc=%h got %b want 1", pc, ifu_req_ready); end
      @(posedge clk);
      @(negedge clk);
      ifu_req_valid = 1'b0;
   endtask

   // Waits for the expected command, optionally stalls it, then accepts it.
   task automatic serve_cmd(input int stall, output int port);
      cmd_t exp;
      int   waited;
      logic [31:0] want_oh;
      port = 0;
      if (cmd_q.size() == 0) begin
         checks++; errors++; $display("[TB] FAIL cmd_queue got empty want entry");
         return;
      end
      exp  = cmd_q.pop_front();
      port = exp.port;
      want_oh = 32'd1 << exp.port;
      waited = 0;
      while (icb_cmd_valid == '0 && waited < 8) begin
         @(posedge clk); @(negedge clk); waited++;
      end
      checks++;
      if (icb_cmd_valid !== want_oh[NPORT-1:0] || icb_cmd_addr !== exp.addr) begin
         errors++;
         $display("[TB] FAIL cmd got valid=%b addr=%h want valid=%b addr=%h", icb_cmd_valid, icb_cmd_addr, want_oh[NPORT-1:0], exp.addr);
      end
      for (int k = 0; k < stall; k++) begin
         @(posedge clk); @(negedge clk);
         checks++;
         if (icb_cmd_valid !== want_oh[NPORT-1:0] || icb_cmd_addr !== exp.addr || ifu_req_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL cmd_hold got valid=%b addr=%h rdy=%b want valid=%b addr=%h rdy=0", icb_cmd_valid, icb_cmd_addr, ifu_req_ready, want_oh[NPORT-1:0], exp.addr);
         end
      end
      icb_cmd_ready = '1;
      @(posedge clk); @(negedge clk);
      icb_cmd_ready = '0;
   endtask

   task automatic serve_rsp(input int port, input logic [63:0] rdata, input logic err);
      logic [31:0] want_oh;
      want_oh = 32'd1 << port;
      icb_rsp_valid = want_oh[NPORT-1:0];
      icb_rsp_err   = err ? want_oh[NPORT-1:0] : '0;
      icb_rsp_rdata = {NPORT{64'hDEAD_DEAD_DEAD_DEAD}};
      icb_rsp_rdata[port*DW +: DW] = rdata;
      checks++;
      if (icb_rsp_ready !== want_oh[NPORT-1:0] || icb_cmd_valid !== '0) begin
         errors++;
         $display("[TB] FAIL rsp_ready got %b cmd=%b want %b cmd=0", icb_rsp_ready, icb_cmd_valid, want_oh[NPORT-1:0]);
      end
      @(posedge clk); @(negedge clk);
      icb_rsp_valid = '0;
      icb_rsp_err   = '0;
   endtask

   task automatic collect_rsp(input int hold);
      rsp_t exp;
      int   waited;
      if (rsp_q.size() == 0) begin
         checks++; errors++; $display("[TB] FAIL rsp_queue got empty want entry");
         return;
      end
      exp = rsp_q.pop_front();
      waited = 0;
      while (ifu_rsp_valid !== 1'b1 && waited < 8) begin
         @(posedge clk); @(negedge clk); waited++;
      end
      checks++;
      if (ifu_rsp_valid !== 1'b1 || ifu_rsp_err !== exp.err || ifu_rsp_instr !== exp.instr || ifu_req_ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL rsp got v=%b err=%b instr=%h rdy=%b want v=1 err=%b instr=%h rdy=0", ifu_rsp_valid, ifu_rsp_err, ifu_rsp_instr, ifu_req_ready, exp.err, exp.instr);
      end
      for (int k = 0; k < hold; k++) begin
         @(posedge clk); @(negedge clk);
         checks++;
         if (ifu_rsp_valid !== 1'b1 || ifu_rsp_err !== exp.err || ifu_rsp_instr !== exp.instr || ifu_req_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rsp_hold got v=%b err=%b instr=%h want v=1 err=%b instr=%h", ifu_rsp_valid, ifu_rsp_err, ifu_rsp_instr, exp.err, exp.instr);
         end
      end
      ifu_rsp_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      ifu_rsp_ready = 1'b0;
      checks++;
      if (ifu_rsp_valid !== 1'b0 || ifu_req_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL rsp_done got v=%b rdy=%b want v=0 rdy=1", ifu_rsp_valid, ifu_req_ready);
      end
   endtask

   task automatic check_idle_outputs(input string name);
      checks++;
      if (ifu_req_ready !== 1'b1 || ifu_rsp_valid !== 1'b0 || ifu_rsp_err !== 1'b0 ||
          ifu_rsp_instr !== 32'h0 || icb_cmd_valid !== '0 || icb_rsp_ready !== '0) begin
         errors++;
         $display("[TB] FAIL %s got rdy=%b v=%b err=%b instr=%h cmd=%b rsprdy=%b want 1 0 0 0 0 0", name,
                  ifu_req_ready, ifu_rsp_valid, ifu_rsp_err, ifu_rsp_instr, icb_cmd_valid, icb_rsp_ready);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check_idle_outputs("reset");
      rst_n = 1'b1;
   endtask

   task automatic test_aligned;
      logic [31:0] pcs [3]   = '{32'h8000_0004, 32'h8000_0000, 32'h8000_0002};
      logic [63:0] data [3]  = '{64'h1122_3344_5566_7788, 64'h0F0E_0D0C_0B0A_0908, 64'hCAFE_F00D_1234_5678};
      logic [31:0] instr [3] = '{32'h1122_3344, 32'h0B0A_0908, 32'hF00D_1234};
      int p;
      for (int i = 0; i < 3; i++) begin
         expect_cmd(0, 32'h8000_0000);
         expect_rsp(1'b0, instr[i]);
         do_req(pcs[i]);
         checks++;
         if (icb_cmd_valid !== 2'b01) begin errors++; $display("[TB] FAIL cmd_latency got %b want 01", icb_cmd_valid); end
         serve_cmd(0, p);
         serve_rsp(p, data[i], 1'b0);
         collect_rsp(0);
      end
   endtask

   task automatic test_cross;
      int p;
      expect_cmd(0, 32'h8000_0000);
      expect_cmd(0, 32'h8000_0008);
      expect_rsp(1'b0, 32'h1234_ABCD);
      do_req(32'h8000_0006);
      serve_cmd(0, p);
      serve_rsp(p, 64'hABCD_5555_6666_7777, 1'b0);
      serve_cmd(0, p);
      serve_rsp(p, 64'h9999_8888_7777_1234, 1'b0);
      collect_rsp(0);
   endtask

   task automatic test_unmapped;
      logic [31:0] pcs [2] = '{32'h1000_0000, 32'h8000_0003};
      for (int i = 0; i < 2; i++) begin
         expect_rsp(1'b1, 32'h0);
         do_req(pcs[i]);
         checks++;
         if (ifu_rsp_valid !== 1'b1 || icb_cmd_valid !== '0) begin
            errors++;
            $display("[TB] FAIL unmapped_latency pc=%h got v=%b cmd=%b want v=1 cmd=0", pcs[i], ifu_rsp_valid, icb_cmd_valid);
         end
         collect_rsp(0);
      end
   endtask

   task automatic test_port_cross;
      int p;
      expect_cmd(0, 32'h8000_FFF8);
      expect_cmd(1, 32'h8001_0000);
      expect_rsp(1'b0, 32'h7788_5566);
      do_req(32'h8000_FFFE);
      serve_cmd(0, p);
      serve_rsp(p, 64'h5566_0000_1111_2222, 1'b0);
      serve_cmd(0, p);
      serve_rsp(p, 64'h3333_4444_5555_7788, 1'b0);
      collect_rsp(0);
   endtask

   task automatic test_cross_unmapped;
      int p;
      expect_cmd(1, 32'h8001_FFF8);
      expect_rsp(1'b1, 32'h0);
      do_req(32'h8001_FFFE);
      serve_cmd(0, p);
      serve_rsp(p, 64'h5566_0000_1111_2222, 1'b0);
      checks++;
      if (icb_cmd_valid !== '0 || ifu_rsp_valid !== 1'b1) begin
         errors++; $display("[TB] FAIL cross_miss got cmd=%b v=%b want cmd=0 v=1", icb_cmd_valid, ifu_rsp_valid);
      end
      collect_rsp(0);
   endtask

   task automatic test_backpressure;
      int p;
      expect_cmd(1, 32'h8001_0000);
      expect_rsp(1'b0, 32'hF00D_1234);
      do_req(32'h8001_0002);
      serve_cmd(3, p);
      serve_rsp(p, 64'hCAFE_F00D_1234_5678, 1'b0);
      collect_rsp(4);
   endtask

   task automatic test_errors;
      int p;
      expect_cmd(0, 32'h8000_0000);
      expect_rsp(1'b1, 32'h0);
      do_req(32'h8000_0006);
      serve_cmd(0, p);
      serve_rsp(p, 64'hABCD_0000_0000_0000, 1'b1);
      checks++;
      if (icb_cmd_valid !== '0 || ifu_rsp_valid !== 1'b1) begin
         errors++; $display("[TB] FAIL beat1_err got cmd=%b v=%b want cmd=0 v=1", icb_cmd_valid, ifu_rsp_valid);
      end
      collect_rsp(0);
      expect_cmd(0, 32'h8000_FFF8);
      expect_cmd(1, 32'h8001_0000);
      expect_rsp(1'b1, 32'h4321_BEEF);
      do_req(32'h8000_FFFE);
      serve_cmd(0, p);
      serve_rsp(p, 64'hBEEF_0000_0000_0000, 1'b0);
      serve_cmd(0, p);
      serve_rsp(p, 64'h0000_0000_0000_4321, 1'b1);
      collect_rsp(0);
   endtask

   task automatic test_reset_mid;
      int p;
      expect_cmd(0, 32'h8000_0000);
      expect_cmd(0, 32'h8000_0008);
      do_req(32'h8000_0006);
      serve_cmd(0, p);
      serve_rsp(p, 64'hABCD_0000_0000_0000, 1'b0);
      serve_cmd(0, p);
      checks++;
      if (icb_rsp_ready !== 2'b01) begin errors++; $display("[TB] FAIL rsp2_state got %b want 01", icb_rsp_ready); end
      rst_n = 1'b0;
      @(posedge clk); @(negedge clk);
      rst_n = 1'b1;
      check_idle_outputs("reset_mid");
      test_aligned();
   endtask

   initial begin
      rst_n         = 1'b0;
      ifu_req_valid = 1'b0;
      ifu_req_pc    = '0;
      ifu_rsp_ready = 1'b0;
      icb_cmd_ready = '0;
      icb_rsp_valid = '0;
      icb_rsp_err   = '0;
      icb_rsp_rdata = '0;
      region_base   = {32'h8001_0000, 32'h8000_0000};
      region_mask   = {32'hFFFF_0000, 32'hFFFF_0000};
      test_reset();
      test_aligned();
      test_cross();
      test_unmapped();
      test_port_cross();
      test_cross_unmapped();
      test_backpressure();
      test_errors();
      test_reset_mid();
      if (cmd_q.size() != 0 || rsp_q.size() != 0) begin
         checks++; errors++;
         $display("[TB] FAIL leftover_queue got cmd=%0d rsp=%0d want 0 0", cmd_q.size(), rsp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
